// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the Tomasulo common data bus.
// Picks one completing unit per cycle and drives the registered CDB
// broadcast (tag + data). The unit granted in the current cycle is masked
// from the next decision, so a single requester wins at most every other
// cycle.
// Optional feature macro: CDB_PRIO_EN -- when defined, unit PRIO_IDX wins
// whenever it is eligible, without moving the round-robin pointer.
module cdb_arbiter #(
    parameter int N_REQ    = 4,
    parameter int TAG_W    = 3,
    parameter int DATA_W   = 16,
    parameter int PRIO_IDX = 1,
    localparam int SRC_W   = $clog2(N_REQ)
) (
    input  logic                      clock,
    input  logic                      Reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*TAG_W-1:0]    req_tag,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic                      cdb_hold,
    output logic [N_REQ-1:0]          grant,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [SRC_W-1:0]          cdb_src,
    output logic                      tag_err
);

    // Reject configurations the arbiter is not built for.
    if ((N_REQ < 2) || (N_REQ > 8) || (PRIO_IDX < 0) || (PRIO_IDX >= N_REQ)) begin : g_param_check
        $error("cdb_arbiter: N_REQ must be 2..8 and PRIO_IDX must index a requester");
    end

    // Registered broadcast state and the round-robin pointer.
    logic [N_REQ-1:0]  grant_q,  grant_d;
    logic              valid_q,  valid_d;
    logic [TAG_W-1:0]  tag_q,    tag_d;
    logic [DATA_W-1:0] data_q,   data_d;
    logic [SRC_W-1:0]  src_q,    src_d;
    logic              err_q,    err_d;
    logic [SRC_W-1:0]  rr_q,     rr_d;

    // Unpacked views of the per-unit tag and data buses.
    logic [TAG_W-1:0]  tag_arr  [N_REQ];
    logic [DATA_W-1:0] data_arr [N_REQ];

    // Winner selection.
    logic [N_REQ-1:0]  eligible;
    logic              win_found;
    logic [SRC_W-1:0]  win_idx;
    logic              prio_win;
    logic [SRC_W-1:0]  cand_idx;
    int                cand;

    // Split the packed request buses into one slot per unit.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            tag_arr[i]  = req_tag[i*TAG_W +: TAG_W];
            data_arr[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Find the winner: priority unit first (if enabled), else the first
    // eligible unit scanning upward from rr_ptr with wrap-around.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        eligible  = req & ~grant_q;
        win_found = 1'b0;
        win_idx   = '0;
        prio_win  = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(rr_q) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = SRC_W'(cand);
            if (!win_found && eligible[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
`ifdef CDB_PRIO_EN
        if (eligible[PRIO_IDX]) begin
            win_found = 1'b1;
            win_idx   = SRC_W'(PRIO_IDX);
            prio_win  = 1'b1;
        end
`else
        prio_win = 1'b0;
`endif
    end

    // Next-state: hold or empty eligible set idles the bus; otherwise
    // broadcast the winner and move the pointer past it.
    always_comb begin
        grant_d = '0;
        valid_d = 1'b0;
        tag_d   = tag_q;
        data_d  = data_q;
        src_d   = src_q;
        err_d   = err_q;
        rr_d    = rr_q;
        if (!cdb_hold && win_found) begin
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            src_d            = win_idx;
            tag_d            = tag_arr[win_idx];
            data_d           = data_arr[win_idx];
            // Tag 0 means "value ready" and must never reach the snoopers.
            if (tag_arr[win_idx] == '0) begin
                valid_d = 1'b0;
                err_d   = 1'b1;
            end else begin
                valid_d = 1'b1;
            end
            if (!prio_win) begin
                rr_d = (win_idx == SRC_W'(N_REQ - 1)) ? '0 : win_idx + SRC_W'(1);
            end
        end
    end

    // State register; reset clears every output at once, dropping any
    // broadcast in flight.
    always_ff @(posedge clock or posedge Reset) begin
        // NOTE: sequential state uses non-blocking assignments so all
        // registers update together from values sampled at the same edge.
        if (Reset) begin
            grant_q <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            src_q   <= '0;
            err_q   <= 1'b0;
            rr_q    <= '0;
        end else begin
            grant_q <= grant_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            src_q   <= src_d;
            err_q   <= err_d;
            rr_q    <= rr_d;
        end
    end

    assign grant     = grant_q;
    assign cdb_valid = valid_q;
    assign cdb_tag   = tag_q;
    assign cdb_data  = data_q;
    assign cdb_src   = src_q;
    assign tag_err   = err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table-driven check of the CDB arbiter with a scoreboard
// queue, plus a hand-written asynchronous-reset sequence.
module tb_cdb_arbiter;

    localparam int N_REQ  = 4;
    localparam int TAG_W  = 3;
    localparam int DATA_W = 16;
    localparam int SRC_W  = 2;

    // Unit tags {u3,u2,u1,u0} and results.
    localparam logic [11:0] TAGS_A = {3'd7, 3'd5, 3'd2, 3'd1};
    localparam logic [11:0] TAGS_B = {3'd6, 3'd5, 3'd2, 3'd1};
    localparam logic [11:0] TAGS_Z = {3'd7, 3'd5, 3'd2, 3'd0};
    localparam logic [63:0] DATA_A = {16'h4400, 16'h3C00, 16'h2A00, 16'h1800};
    localparam logic [63:0] DATA_B = {16'h5A5A, 16'h3C00, 16'h2A00, 16'h1800};

    logic                     clock = 1'b0;
    logic                     Reset = 1'b1;
    logic [N_REQ-1:0]         req = '0;
    logic [N_REQ*TAG_W-1:0]   req_tag = '0;
    logic [N_REQ*DATA_W-1:0]  req_data = '0;
    logic                     cdb_hold = 1'b0;
    logic [N_REQ-1:0]         grant;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [DATA_W-1:0]        cdb_data;
    logic [SRC_W-1:0]         cdb_src;
    logic                     tag_err;

    cdb_arbiter #(
        .N_REQ(N_REQ), .TAG_W(TAG_W), .DATA_W(DATA_W), .PRIO_IDX(1)
    ) dut (
        .clock(clock), .Reset(Reset),
        .req(req), .req_tag(req_tag), .req_data(req_data), .cdb_hold(cdb_hold),
        .grant(grant), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_src(cdb_src), .tag_err(tag_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  g;
        logic        v;
        logic [2:0]  t;
        logic [15:0] d;
        logic [1:0]  s;
        logic        e;
    } exp_t;

    typedef struct {
        logic [3:0]  req;
        logic        hold;
        logic [11:0] tags;
        logic [63:0] data;
        exp_t        exp;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic h, input logic [11:0] tg,
                                input logic [63:0] dt, input logic [3:0] g, input logic v,
                                input logic [2:0] t, input logic [15:0] d, input logic [1:0] s,
                                input logic e);
        vec_t x;
        x.req = r; x.hold = h; x.tags = tg; x.data = dt;
        x.exp.g = g; x.exp.v = v; x.exp.t = t; x.exp.d = d; x.exp.s = s; x.exp.e = e;
        return x;
    endfunction

    initial begin
        exp_t ex;

        // Idle, single unit, hold, release to rr_ptr's unit.
        vecs.push_back(mk(4'b0000, 0, TAGS_A, DATA_A, 4'b0000, 0, 3'd0, 16'h0000, 2'd0, 0));
        vecs.push_back(mk(4'b0100, 0, TAGS_A, DATA_A, 4'b0100, 1, 3'd5, 16'h3C00, 2'd2, 0));
        vecs.push_back(mk(4'b0000, 0, TAGS_A, DATA_A, 4'b0000, 0, 3'd5, 16'h3C00, 2'd2, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(4'b1001, 1, TAGS_A, DATA_A, 4'b0000, 0, 3'd5, 16'h3C00, 2'd2, 0));
        vecs.push_back(mk(4'b1001, 0, TAGS_A, DATA_A, 4'b1000, 1, 3'd7, 16'h4400, 2'd3, 0));
        vecs.push_back(mk(4'b0001, 0, TAGS_A, DATA_A, 4'b0001, 1, 3'd1, 16'h1800, 2'd0, 0));
        vecs.push_back(mk(4'b0000, 0, TAGS_A, DATA_A, 4'b0000, 0, 3'd1, 16'h1800, 2'd0, 0));
        // Single unit holding req: granted every other cycle.
        vecs.push_back(mk(4'b0100, 0, TAGS_A, DATA_A, 4'b0100, 1, 3'd5, 16'h3C00, 2'd2, 0));
        vecs.push_back(mk(4'b0100, 0, TAGS_A, DATA_A, 4'b0000, 0, 3'd5, 16'h3C00, 2'd2, 0));
        vecs.push_back(mk(4'b0100, 0, TAGS_A, DATA_A, 4'b0100, 1, 3'd5, 16'h3C00, 2'd2, 0));
        vecs.push_back(mk(4'b0000, 0, TAGS_A, DATA_A, 4'b0000, 0, 3'd5, 16'h3C00, 2'd2, 0));
        // Tag/data changed while waiting under hold: latest values broadcast.
        vecs.push_back(mk(4'b1000, 1, TAGS_B, DATA_B, 4'b0000, 0, 3'd5, 16'h3C00, 2'd2, 0));
        vecs.push_back(mk(4'b1000, 0, TAGS_B, DATA_B, 4'b1000, 1, 3'd6, 16'h5A5A, 2'd3, 0));
        vecs.push_back(mk(4'b0000, 0, TAGS_A, DATA_A, 4'b0000, 0, 3'd6, 16'h5A5A, 2'd3, 0));
        // All units requesting, starting from rr_ptr = 0.
`ifdef CDB_PRIO_EN
        vecs.push_back(mk(4'b1111, 0, TAGS_A, DATA_A, 4'b0010, 1, 3'd2, 16'h2A00, 2'd1, 0));
        vecs.push_back(mk(4'b1111, 0, TAGS_A, DATA_A, 4'b0001, 1, 3'd1, 16'h1800, 2'd0, 0));
        vecs.push_back(mk(4'b1111, 0, TAGS_A, DATA_A, 4'b0010, 1, 3'd2, 16'h2A00, 2'd1, 0));
        vecs.push_back(mk(4'b1111, 0, TAGS_A, DATA_A, 4'b0100, 1, 3'd5, 16'h3C00, 2'd2, 0));
        vecs.push_back(mk(4'b1111, 0, TAGS_A, DATA_A, 4'b0010, 1, 3'd2, 16'h2A00, 2'd1, 0));
        vecs.push_back(mk(4'b1111, 0, TAGS_A, DATA_A, 4'b1000, 1, 3'd7, 16'h4400, 2'd3, 0));
        vecs.push_back(mk(4'b0000, 0, TAGS_A, DATA_A, 4'b0000, 0, 3'd7, 16'h4400, 2'd3, 0));
`else
        vecs.push_back(mk(4'b1111, 0, TAGS_A, DATA_A, 4'b0001, 1, 3'd1, 16'h1800, 2'd0, 0));
        vecs.push_back(mk(4'b1111, 0, TAGS_A, DATA_A, 4'b0010, 1, 3'd2, 16'h2A00, 2'd1, 0));
        vecs.push_back(mk(4'b1111, 0, TAGS_A, DATA_A, 4'b0100, 1, 3'd5, 16'h3C00, 2'd2, 0));
        vecs.push_back(mk(4'b1111, 0, TAGS_A, DATA_A, 4'b1000, 1, 3'd7, 16'h4400, 2'd3, 0));
        vecs.push_back(mk(4'b1111, 0, TAGS_A, DATA_A, 4'b0001, 1, 3'd1, 16'h1800, 2'd0, 0));
        vecs.push_back(mk(4'b0000, 0, TAGS_A, DATA_A, 4'b0000, 0, 3'd1, 16'h1800, 2'd0, 0));
`endif
        // Tag zero: granted, not valid, sticky error.
        vecs.push_back(mk(4'b0001, 0, TAGS_Z, DATA_A, 4'b0001, 0, 3'd0, 16'h1800, 2'd0, 1));
        vecs.push_back(mk(4'b0000, 0, TAGS_A, DATA_A, 4'b0000, 0, 3'd0, 16'h1800, 2'd0, 1));
        vecs.push_back(mk(4'b0100, 0, TAGS_A, DATA_A, 4'b0100, 1, 3'd5, 16'h3C00, 2'd2, 1));
        vecs.push_back(mk(4'b0000, 0, TAGS_A, DATA_A, 4'b0000, 0, 3'd5, 16'h3C00, 2'd2, 1));

        // Reset state.
        #1;
        check("reset grant", 64'(grant), 64'h0);
        check("reset valid", 64'(cdb_valid), 64'h0);
        check("reset tag", 64'(cdb_tag), 64'h0);
        check("reset data", 64'(cdb_data), 64'h0);
        check("reset src", 64'(cdb_src), 64'h0);
        check("reset err", 64'(tag_err), 64'h0);
        @(negedge clock);
        Reset = 1'b0;

        // Apply the table: push expectations as stimulus goes in, pop after the edge.
        foreach (vecs[k]) begin
            req      = vecs[k].req;
            cdb_hold = vecs[k].hold;
            req_tag  = vecs[k].tags;
            req_data = vecs[k].data;
            sb.push_back(vecs[k].exp);
            @(negedge clock);
            ex = sb.pop_front();
            check($sformatf("v%0d grant", k), 64'(grant), 64'(ex.g));
            check($sformatf("v%0d valid", k), 64'(cdb_valid), 64'(ex.v));
            check($sformatf("v%0d tag", k), 64'(cdb_tag), 64'(ex.t));
            check($sformatf("v%0d data", k), 64'(cdb_data), 64'(ex.d));
            check($sformatf("v%0d src", k), 64'(cdb_src), 64'(ex.s));
            check($sformatf("v%0d err", k), 64'(tag_err), 64'(ex.e));
        end

        // Reset mid-broadcast with everyone requesting.
        req      = 4'b1111;
        cdb_hold = 1'b0;
        req_tag  = TAGS_A;
        req_data = DATA_A;
        @(posedge clock);
        #2;
        check("pre-reset valid", 64'(cdb_valid), 64'h1);
        Reset = 1'b1;
        #1;
        check("async reset grant", 64'(grant), 64'h0);
        check("async reset valid", 64'(cdb_valid), 64'h0);
        check("async reset tag", 64'(cdb_tag), 64'h0);
        check("async reset data", 64'(cdb_data), 64'h0);
        check("async reset src", 64'(cdb_src), 64'h0);
        check("async reset err", 64'(tag_err), 64'h0);
        @(negedge clock);
        Reset = 1'b0;
        @(negedge clock);
`ifdef CDB_PRIO_EN
        check("post-reset grant", 64'(grant), 64'h2);
        check("post-reset src", 64'(cdb_src), 64'h1);
`else
        check("post-reset grant", 64'(grant), 64'h1);
        check("post-reset src", 64'(cdb_src), 64'h0);
`endif
        check("post-reset valid", 64'(cdb_valid), 64'h1);
        req = '0;
        @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
